// File: rtl/lmac_reg_pkg.sv
// ---------------------------------------------------------------------------
// lmac_reg_pkg
// Shared definitions for the LMAC register read master: the FSM state
// encoding, address/data/counter widths and the parameter defaults.
// ---------------------------------------------------------------------------
package lmac_reg_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned        DEF_TIMEOUT_CYCLES = 255;
  localparam logic [DATA_W-1:0]  DEF_ERR_DATA       = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/lmac_reg_rd_master.sv
// ---------------------------------------------------------------------------
// lmac_reg_rd_master
// Turns a host read request into a one-cycle read strobe on the MAC register
// port, waits for the MAC completion (bounded by TIMEOUT_CYCLES), and returns
// the read data -- or ERR_DATA with rsp_err=1 on timeout -- to the host.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side (req_valid/req_ready) and the response side
// (rsp_valid/rsp_ready) both follow that rule; once rsp_valid is raised it
// stays high with rsp_data/rsp_err stable until the transfer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   host request handshake, req_addr = register address
//   rsp_valid/ready   host response handshake, rsp_data/rsp_err = result
//   host_addr_reg     address presented to the MAC register port
//   reg_rd_start      one-cycle read strobe to the MAC
//   reg_rd_done_out   MAC read complete; FMAC_REGDOUT valid in that cycle
//   err_count         saturating count of timed-out reads
//   state_dbg         current FSM state, for observation only
// ---------------------------------------------------------------------------
module lmac_reg_rd_master
  import lmac_reg_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] host_addr_reg,
  output logic              reg_rd_start,
  input  logic              reg_rd_done_out,
  input  logic [DATA_W-1:0] FMAC_REGDOUT,
  output logic [CNT_W-1:0]  err_count,
  output state_t            state_dbg
);

  // Timeout fires in the WAIT cycle whose increment brings the counter to
  // TIMEOUT_CYCLES-1. The counter is 0 in the first WAIT cycle, so the read
  // spends TIMEOUT_CYCLES-1 cycles in WAIT and the response appears
  // TIMEOUT_CYCLES cycles after the strobe. 17-bit compare so that
  // TIMEOUT_CYCLES=1 (target 0) fires immediately instead of never.
  localparam logic [CNT_W:0] TIMEOUT_LAST = (CNT_W+1)'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             cap_good;
  logic             cap_timeout;

  assign timeout_hit = (({1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= TIMEOUT_LAST);
  assign state_dbg   = state;

  // Next-state and handshake outputs
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    reg_rd_start = 1'b0;
    rsp_valid    = 1'b0;
    cap_good     = 1'b0;
    cap_timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_START;
      end
      ST_START: begin
        // Any done seen here belongs to no outstanding read and is dropped.
        reg_rd_start = 1'b1;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        // Done is checked first so a completion on the timeout cycle wins.
        if (reg_rd_done_out) begin
          cap_good   = 1'b1;
          state_next = ST_RESP;
        end else if (timeout_hit) begin
          cap_timeout = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      host_addr_reg <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      err_count     <= '0;
    end else begin
      state <= state_next;

      if (state == ST_IDLE && req_valid) host_addr_reg <= req_addr;

      if (state == ST_START)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

      if (cap_good) begin
        rsp_data <= FMAC_REGDOUT;
        rsp_err  <= 1'b0;
      end else if (cap_timeout) begin
        rsp_data <= ERR_DATA;
        rsp_err  <= 1'b1;
        if (err_count != {CNT_W{1'b1}})
          err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_lmac_reg_rd_master.sv
// ---------------------------------------------------------------------------
// tb_lmac_reg_rd_master
// Directed bench for lmac_reg_rd_master with TIMEOUT_CYCLES=8. Inputs are
// driven just after the falling edge and outputs are observed at the falling
// edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_lmac_reg_rd_master;
  import lmac_reg_pkg::*;

  localparam int unsigned TMO = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] host_addr_reg;
  logic              reg_rd_start;
  logic              reg_rd_done_out = 1'b0;
  logic [DATA_W-1:0] FMAC_REGDOUT = '0;
  logic [CNT_W-1:0]  err_count;
  state_t            state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  lmac_reg_rd_master #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .host_addr_reg  (host_addr_reg),
    .reg_rd_start   (reg_rd_start),
    .reg_rd_done_out(reg_rd_done_out),
    .FMAC_REGDOUT   (FMAC_REGDOUT),
    .err_count      (err_count),
    .state_dbg      (state_dbg)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a read, never signal done, take the timeout response.
  task automatic do_timeout(input logic [15:0] addr, input logic [15:0] exp_cnt);
    req_valid = 1'b1;
    req_addr  = addr;
    step();                       // START
    req_valid = 1'b0;
    chk("tmo_start", 32'(reg_rd_start), 32'd1);
    for (int i = 1; i <= int'(TMO); i++) begin
      step();
      if (i < int'(TMO)) chk("tmo_no_rsp_yet", 32'(rsp_valid), 32'd0);
    end
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_rsp_data", rsp_data, 32'hFFFF_FFFF);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_err_count", 32'(err_count), 32'(exp_cnt));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("tmo_back_idle", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    // ---------------- reset state ----------------
    @(negedge clk);
    step();
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd_start", 32'(reg_rd_start), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_host_addr", 32'(host_addr_reg), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // ---------------- good read: accept c0, done c3 ----------------
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    chk("good_req_ready_c0", 32'(req_ready), 32'd1);
    chk("good_start_c0", 32'(reg_rd_start), 32'd0);
    step();                                   // cycle 1
    req_valid = 1'b0;
    chk("good_start_c1", 32'(reg_rd_start), 32'd1);
    chk("good_addr", 32'(host_addr_reg), 32'h0010);
    chk("good_req_ready_c1", 32'(req_ready), 32'd0);
    step();                                   // cycle 2
    chk("good_start_c2", 32'(reg_rd_start), 32'd0);
    step();                                   // cycle 3
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'h0000_0808;
    chk("good_no_rsp_c3", 32'(rsp_valid), 32'd0);
    step();                                   // cycle 4
    reg_rd_done_out = 1'b0;
    FMAC_REGDOUT    = 32'hDEAD_BEEF;
    chk("good_rsp_valid_c4", 32'(rsp_valid), 32'd1);
    chk("good_rsp_data", rsp_data, 32'h0000_0808);
    chk("good_rsp_err", 32'(rsp_err), 32'd0);
    chk("good_start_c4", 32'(reg_rd_start), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("good_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("good_rsp_drop", 32'(rsp_valid), 32'd0);

    // ---------------- timeout ----------------
    do_timeout(16'h0100, 16'd1);

    // ---------------- backpressure + minimum spacing ----------------
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    step();                                   // START
    req_valid = 1'b0;
    step();                                   // WAIT, immediate done
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'hA5A5_1234;
    step();                                   // RESP
    reg_rd_done_out = 1'b0;
    FMAC_REGDOUT    = 32'h0;
    req_valid = 1'b1;
    req_addr  = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'hA5A5_1234);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("bp_addr_held", 32'(host_addr_reg), 32'h0020);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("bp_err_count", 32'(err_count), 32'd1);

    // ---------------- done on the timeout cycle wins ----------------
    req_valid = 1'b1;
    req_addr  = 16'h0044;
    step();                                   // START (S)
    req_valid = 1'b0;
    for (int i = 1; i < int'(TMO) - 1; i++) step();   // S+6
    chk("tie_no_rsp", 32'(rsp_valid), 32'd0);
    step();                                   // S+7: timeout cycle
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'h1111_2222;
    step();
    reg_rd_done_out = 1'b0;
    chk("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tie_rsp_data", rsp_data, 32'h1111_2222);
    chk("tie_rsp_err", 32'(rsp_err), 32'd0);
    chk("tie_err_count", 32'(err_count), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- spurious done in IDLE ----------------
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("spur_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    chk("spur_rsp_data", rsp_data, 32'h1111_2222);

    // ---------------- done during START is ignored ----------------
    req_valid = 1'b1;
    req_addr  = 16'h0055;
    reg_rd_done_out = 1'b0;
    step();                                   // START
    req_valid = 1'b0;
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'hBAD0_BAD0;
    step();                                   // WAIT
    reg_rd_done_out = 1'b0;
    chk("start_done_ignored", 32'(rsp_valid), 32'd0);
    chk("start_done_state", 32'(state_dbg), 32'(ST_WAIT));
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'h0000_5555;
    step();
    reg_rd_done_out = 1'b0;
    chk("start_done_data", rsp_data, 32'h0000_5555);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- reset in WAIT, late done ----------------
    req_valid = 1'b1;
    req_addr  = 16'h0040;
    step();                                   // START
    req_valid = 1'b0;
    step();                                   // WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mid_rst_addr", 32'(host_addr_reg), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'hCAFE_0000;
    step();
    reg_rd_done_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done_no_rsp", 32'(rsp_valid), 32'd0);
      chk("late_done_no_start", 32'(reg_rd_start), 32'd0);
      step();
    end
    req_valid = 1'b1;
    req_addr  = 16'h0050;
    step();
    req_valid = 1'b0;
    chk("after_rst_start", 32'(reg_rd_start), 32'd1);
    step();
    reg_rd_done_out = 1'b1;
    FMAC_REGDOUT    = 32'h0000_0050;
    step();
    reg_rd_done_out = 1'b0;
    chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("after_rst_rsp_data", rsp_data, 32'h0000_0050);
    chk("after_rst_addr", 32'(host_addr_reg), 32'h0050);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // ---------------- saturation (counter preloaded near the top) ----------------
    force dut.err_count = 16'hFFFE;
    step();
    release dut.err_count;
    step();
    do_timeout(16'h0200, 16'hFFFF);
    do_timeout(16'h0201, 16'hFFFF);
    do_timeout(16'h0202, 16'hFFFF);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lmac_reg_rd_master.md
LMAC_REG_RD_MASTER -- requirements
Module: lmac_reg_rd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles allowed before a read is declared failed; legal range 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF: value returned on rsp_data when a read times out.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  host read request valid.
REQ-006 req_ready  output  1  block accepts a request.
REQ-007 req_addr  input  16  MAC register address to read.
REQ-008 rsp_valid  output  1  response valid.
REQ-009 rsp_ready  input  1  host accepts the response.
REQ-010 rsp_data  output  32  read data, or ERR_DATA on timeout.
REQ-011 rsp_err  output  1  1 = timeout, 0 = good read.
REQ-012 host_addr_reg  output  16  address driven to the MAC register port.
REQ-013 reg_rd_start  output  1  read strobe to the MAC, one-cycle pulse.
REQ-014 reg_rd_done_out  input  1  MAC read-complete indication.
REQ-015 FMAC_REGDOUT  input  32  MAC read data; valid in the cycle reg_rd_done_out=1.
REQ-016 err_count  output  16  saturating count of timed-out reads.

Function
REQ-017 FSM states are IDLE, START, WAIT and RESP, and exactly one is active.
REQ-018 IDLE: req_ready=1; on req_valid&req_ready, latch req_addr into host_addr_reg and go to START.
REQ-019 START: reg_rd_start=1 for exactly this one cycle, clear the wait counter, go to WAIT.
REQ-020 WAIT: the wait counter increments each cycle; reg_rd_done_out=1 latches FMAC_REGDOUT into rsp_data, sets rsp_err=0 and goes to RESP.
REQ-021 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without done, rsp_data=ERR_DATA, rsp_err=1, err_count increments (saturating at 16'hFFFF), and the FSM goes to RESP.
REQ-022 Done and timeout in the same cycle: done wins, the read is good, and err_count is unchanged.
REQ-023 RESP: rsp_valid=1, with rsp_data/rsp_err stable until rsp_valid&rsp_ready, then go to IDLE.
REQ-024 req_ready=0 in START, WAIT and RESP; only one read is outstanding at a time.
REQ-025 reg_rd_done_out outside WAIT (including in START) is ignored.
REQ-026 host_addr_reg holds the last accepted address until the next accept.
REQ-027 Latency: accept at cycle N -> reg_rd_start at N+1; done at cycle M -> rsp_valid at M+1.
REQ-028 Minimum request-to-request spacing is 4 cycles (accept, START, WAIT with immediate done, RESP with immediate ready).

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, reg_rd_start=0, rsp_valid=0, rsp_err=0, rsp_data=0, host_addr_reg=0, err_count=0, wait counter=0.
REQ-030 Reset mid-read aborts with no response and no further reg_rd_start; a late reg_rd_done_out after reset is ignored.
REQ-031 The first cycle after reset deasserts is IDLE, with req_ready=1.

Structure
REQ-032 Shared package lmac_reg_pkg holds the FSM state encoding, the TIMEOUT_CYCLES and ERR_DATA defaults, and the 16/32-bit address and data width constants.
REQ-033 The block is a single flat module with no sub-module; the wait counter width is 16 bits.

Verification
REQ-034 Good read: req_addr=16'h0010 accepted at cycle 0, MAC done at cycle 3 with FMAC_REGDOUT=32'h0000_0808 -> reg_rd_start only at cycle 1, rsp_valid at cycle 4, rsp_data=32'h0000_0808, rsp_err=0.
REQ-035 Timeout: TIMEOUT_CYCLES=8 and no done -> rsp_valid 8 cycles after reg_rd_start, rsp_data=32'hFFFF_FFFF, rsp_err=1, err_count=1.
REQ-036 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data and rsp_err stable, req_ready=0 throughout, and a new req_valid is not accepted.
REQ-037 Edge cases:
- Done in the same cycle as the timeout -> good read, err_count unchanged.
- Spurious done in IDLE -> no response and no state change.
REQ-038 Reset in WAIT, with a done pulse 2 cycles later -> no rsp_valid, all outputs at reset values, next request served normally.
REQ-039 Saturation: 65536 forced timeouts -> err_count stays at 16'hFFFF.
